// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory access arbiter.
// Holds the arbiter FSM state encoding and the default data-memory size.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DATA_MEM_SIZE_DEF = 128;

endpackage

// File: rtl/dm_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// A lone request wins outright. On a tie the port that did not win last time
// is granted. The last-grant history register lives in the parent.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Tie goes to the port opposite the previous winner.
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares one byte-addressed, big-endian data memory between the CPU MEM stage
// (port 0) and a DMA / loader port (port 1).
// A request is latched in IDLE or RESP, presented to the memory for a single
// ACCESS cycle, and acknowledged with a one-cycle pulse in RESP. Read data is
// forwarded straight from the memory's registered output while the ack is high.
// Optional build macro DM_ADDR_CHECK_EN: adds p0_err/p1_err and blocks
// misaligned or out-of-range accesses from reaching the memory.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEF,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_write,
  output logic              dm_read,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              busy,
`ifdef DM_ADDR_CHECK_EN
  output logic              p0_err,
  output logic              p1_err,
`endif
  output logic              gnt_id
);

  state_t            state;
  logic              last_gnt;
  logic              we_q;
  logic [1:0]        arb_req;
  logic              arb_valid;
  logic              arb_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;
  logic              rd_ok;

`ifdef DM_ADDR_CHECK_EN
  logic bad_q;

  // Word access must be aligned and fit entirely inside the memory.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= ADDR_W'(DATA_MEM_SIZE - 4));
  endfunction

  assign sel_ok = addr_ok(sel_addr);
  assign rd_ok  = ~we_q & ~bad_q;
`else
  assign sel_ok = 1'b1;
  assign rd_ok  = ~we_q;
`endif

  // In RESP the port being acked may still hold req high; it must not win again.
  always_comb begin
    arb_req = {p1_req, p0_req};
    if (state == RESP) begin
      arb_req[gnt_id] = 1'b0;
    end
  end

  rr_arb2 u_arb (
    .req       (arb_req),
    .last_gnt  (last_gnt),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign sel_we    = arb_id ? p1_we    : p0_we;
  assign sel_addr  = arb_id ? p1_addr  : p0_addr;
  assign sel_wdata = arb_id ? p1_wdata : p0_wdata;

  assign busy = (state != IDLE);

  // Memory output is registered at the end of ACCESS, so it is valid during RESP.
  assign p0_rdata = (p0_ack && rd_ok) ? dm_rdata : '0;
  assign p1_rdata = (p1_ack && rd_ok) ? dm_rdata : '0;

  // Arbiter FSM: latch winner, drive one memory cycle, then pulse the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      we_q     <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_write <= 1'b0;
      dm_read  <= 1'b0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
`ifdef DM_ADDR_CHECK_EN
      bad_q    <= 1'b0;
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
`endif
    end else begin
      dm_write <= 1'b0;
      dm_read  <= 1'b0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
`ifdef DM_ADDR_CHECK_EN
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
`endif
      case (state)
        IDLE, RESP: begin
          if (arb_valid) begin
            state    <= ACCESS;
            last_gnt <= arb_id;
            gnt_id   <= arb_id;
            we_q     <= sel_we;
            dm_addr  <= sel_addr;
            dm_wdata <= sel_wdata;
            dm_write <= sel_we & sel_ok;
            dm_read  <= ~sel_we & sel_ok;
`ifdef DM_ADDR_CHECK_EN
            bad_q    <= ~sel_ok;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state  <= RESP;
          p0_ack <= ~gnt_id;
          p1_ack <= gnt_id;
`ifdef DM_ADDR_CHECK_EN
          p0_err <= ~gnt_id & bad_q;
          p1_err <= gnt_id & bad_q;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a small big-endian memory model.
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_write, dm_read;
  logic [31:0] dm_rdata = 32'h0;
  logic        busy, gnt_id;
`ifdef DM_ADDR_CHECK_EN
  logic        p0_err, p1_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:127];
  bit         mem_ready = 1'b0;

  dm_access_arbiter #(.DATA_MEM_SIZE(128), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_rdata (p1_rdata),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_write (dm_write),
    .dm_read  (dm_read),
    .dm_rdata (dm_rdata),
    .busy     (busy),
`ifdef DM_ADDR_CHECK_EN
    .p0_err   (p0_err),
    .p1_err   (p1_err),
`endif
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  // Memory model: preset pattern mem[i]=i, writes commit on negedge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      mem_ready = 1'b1;
    end else if (dm_write) begin
      for (int i = 0; i < 4; i++) mem[(int'(dm_addr[6:0]) + i) % 128] = dm_wdata[31-8*i -: 8];
    end
  end

  // Memory model: registered read data at posedge.
  always @(posedge clk) begin
    if (dm_read) begin
      dm_rdata <= {mem[int'(dm_addr[6:0])], mem[(int'(dm_addr[6:0]) + 1) % 128],
                   mem[(int'(dm_addr[6:0]) + 2) % 128], mem[(int'(dm_addr[6:0]) + 3) % 128]};
    end
  end

  // Mutual-exclusion invariants sampled every cycle.
  always @(negedge clk) begin
    total++;
    assert (!(p0_ack && p1_ack) && !(dm_write && dm_read)) else begin
      bad++;
      $error("FAIL excl observed=ack%b%b wr%b rd%b expected=not both", p0_ack, p1_ack, dm_write, dm_read);
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    tick(); tick();
    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    chk("rst_acks", {30'd0, p1_ack, p0_ack}, 0);
    chk("rst_dm", {30'd0, dm_write, dm_read}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    rst = 1'b0;

    // 1: port 0 write then read @0x10
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    tick();
    chk("t1_access_ctl", {29'd0, busy, dm_write, dm_read}, 32'b110);
    chk("t1_addr", dm_addr, 32'h10);
    chk("t1_wdata", dm_wdata, 32'hDEADBEEF);
    chk("t1_noack_yet", 32'(p0_ack), 0);
    tick();
    chk("t1_wr_ack", {30'd0, p1_ack, p0_ack}, 32'b01);
    chk("t1_wr_rdata", p0_rdata, 0);
    chk("t1_mem", mem_word(32'h10), 32'hDEADBEEF);
    chk("t1_byte10", 32'(mem[16]), 32'hDE);
    chk("t1_byte13", 32'(mem[19]), 32'hEF);
`ifdef DM_ADDR_CHECK_EN
    chk("t1_noerr", 32'(p0_err), 0);
`endif
    p0_req = 0;
    tick();
    chk("t1_idle", {30'd0, busy, p0_ack}, 0);
    p0_req = 1; p0_we = 0;
    tick();
    chk("t1_rd_ctl", {30'd0, dm_write, dm_read}, 32'b01);
    tick();
    chk("t1_rd_ack", 32'(p0_ack), 1);
    chk("t1_rd_data", p0_rdata, 32'hDEADBEEF);
    p0_req = 0;
    tick();

    // 2: both from reset, p0 wins first
    rst = 1'b1; tick(); rst = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    tick();
    chk("t2_gnt0", 32'(gnt_id), 0);
    chk("t2_addr0", dm_addr, 32'h0);
    tick();
    chk("t2_ack0", {30'd0, p1_ack, p0_ack}, 32'b01);
    chk("t2_data0", p0_rdata, 32'h00010203);
    p0_req = 0;
    tick();
    chk("t2_gnt1", 32'(gnt_id), 1);
    chk("t2_addr1", dm_addr, 32'h4);
    chk("t2_gap", {30'd0, p1_ack, p0_ack}, 0);
    tick();
    chk("t2_ack1", {30'd0, p1_ack, p0_ack}, 32'b10);
    chk("t2_data1", p1_rdata, 32'h04050607);
    chk("t2_p0_quiet", p0_rdata, 0);
    p1_req = 0;
    tick();

    // 3: sustained contention alternates grants
    p0_req = 1; p0_addr = 32'h8;
    p1_req = 1; p1_addr = 32'hC;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("t3_access_noack", {30'd0, p1_ack, p0_ack}, 0);
      tick();
      if (n % 2 == 0) begin
        chk("t3_ack_p0", {30'd0, p1_ack, p0_ack}, 32'b01);
        chk("t3_data_p0", p0_rdata, 32'h08090A0B);
      end else begin
        chk("t3_ack_p1", {30'd0, p1_ack, p0_ack}, 32'b10);
        chk("t3_data_p1", p1_rdata, 32'h0C0D0E0F);
      end
      if (n == 7) begin
        p0_req = 0; p1_req = 0;
      end
    end
    tick();
    chk("t3_idle", 32'(busy), 0);

    // 4: p1 write vs p0 read same cycle; last grant was p1 so p0 goes first
    p0_req = 1; p0_we = 0; p0_addr = 32'h20;
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
    tick();
    chk("t4_first_gnt", 32'(gnt_id), 0);
    tick();
    chk("t4_old_data", p0_rdata, 32'h20212223);
    p0_req = 0;
    tick();
    chk("t4_wr_ctl", {30'd0, dm_write, dm_read}, 32'b10);
    tick();
    chk("t4_wr_ack", {30'd0, p1_ack, p0_ack}, 32'b10);
    chk("t4_wr_rdata", p1_rdata, 0);
    p1_req = 0;
    tick();
    p0_req = 1;
    tick(); tick();
    chk("t4_new_data", p0_rdata, 32'h12345678);
    p0_req = 0;
    tick();

    // 5: reset during a write ACCESS, before the negedge
    p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'hFFFFFFFF;
    tick();
    chk("t5_wr_started", 32'(dm_write), 1);
    rst = 1'b1;
    #1;
    chk("t5_wr_dropped", {29'd0, busy, dm_write, dm_read}, 0);
    chk("t5_outs", dm_addr | dm_wdata | p0_rdata | p1_rdata, 0);
    chk("t5_gnt", 32'(gnt_id), 0);
    p0_req = 0;
    tick();
    chk("t5_mem", mem_word(32'h30), 32'h30313233);
    rst = 1'b0;
    tick();
    chk("t5_noack", {30'd0, p1_ack, p0_ack}, 0);
    chk("t5_idle", 32'(busy), 0);

`ifdef DM_ADDR_CHECK_EN
    // 6: misaligned and out-of-range reads are rejected
    p0_req = 1; p0_we = 0; p0_addr = 32'h7E;
    tick();
    chk("t6a_no_read", {30'd0, dm_write, dm_read}, 0);
    tick();
    chk("t6a_ack_err", {30'd0, p0_err, p0_ack}, 32'b11);
    chk("t6a_rdata", p0_rdata, 0);
    p0_req = 0;
    tick();
    p0_req = 1; p0_addr = 32'h7D;
    tick();
    chk("t6b_no_read", {30'd0, dm_write, dm_read}, 0);
    tick();
    chk("t6b_ack_err", {30'd0, p0_err, p0_ack}, 32'b11);
    chk("t6b_rdata", p0_rdata, 0);
    chk("t6b_p1_err", 32'(p1_err), 0);
    p0_req = 0;
    tick();
    p0_req = 1; p0_addr = 32'h80;
    tick(); tick();
    chk("t6c_ack_err", {30'd0, p0_err, p0_ack}, 32'b11);
    p0_req = 0;
    tick();
    p0_req = 1; p0_addr = 32'h7C;
    tick();
    chk("t6d_read", 32'(dm_read), 1);
    tick();
    chk("t6d_ok", {30'd0, p0_err, p0_ack}, 32'b01);
    chk("t6d_data", p0_rdata, 32'h7C7D7E7F);
    p0_req = 0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
